q_meter: RTL
============

# q_meter

Measurement front end that closes the loop with the bisection current controller. It applies the controller's `i_ref` to the resonator, excites it, and counts oscillation periods during ring-down between two envelope thresholds. It publishes the count as `q_measured` together with a one-cycle `ready` strobe. It runs continuously while enabled and restarts whenever `i_ref` changes.

## Interface
- `BUS_WIDTH`, 10 — width of `i_ref` and `q_measured`.
- `SETTLE_CYCLES`, 64 — wait after a new `i_ref` before excitation (≥1).
- `EXCITE_CYCLES`, 32 — length of the `excite` burst (≥1).
- `MAX_CYCLES`, 65535 — timeout for the decay phases (WAIT_HI plus COUNT).

Ports:
- `clk` in 1 — single clock.
- `rst_n` in 1 — reset is synchronous and active-low.
- `enable` in 1 — run measurements; low forces IDLE.
- `i_ref` in BUS_WIDTH — bias current code from the controller.
- `osc_in` in 1 — asynchronous comparator output of the resonator signal.
- `env_hi` in 1 — asynchronous; envelope above the upper threshold.
- `env_lo` in 1 — asynchronous; envelope above the lower threshold.
- `i_drive` out BUS_WIDTH — registered copy of `i_ref` applied to the DAC.
- `excite` out 1 — excitation drive.
- `q_measured` out BUS_WIDTH — last result, held between updates.
- `ready` out 1 — one-cycle pulse; `q_measured` is valid in the same cycle.
- `timeout` out 1 — set with `ready` when the last result timed out.
- `busy` out 1 — high in any state other than IDLE.

## Operation
- Input synchronisation:
  - `osc_in`, `env_hi` and `env_lo` each pass through a 2-FF synchroniser.
  - An `osc_in` rising edge is detected with a third FF.
- States: IDLE → SETTLE → EXCITE → WAIT_HI → COUNT → DONE → SETTLE.
- IDLE:
  - Outputs `excite=0`.
  - Goes to SETTLE when `enable=1`, latching `i_drive<=i_ref`.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then goes to EXCITE.
- EXCITE:
  - Holds `excite=1` for EXCITE_CYCLES cycles, then goes to WAIT_HI.
- WAIT_HI:
  - Waits for the synced `env_hi` to be 0 (decay has passed the upper threshold).
  - Clears the period counter, then goes to COUNT.
- COUNT:
  - Increments the period counter on each synced `osc_in` rising edge.
  - The counter saturates at 2^BUS_WIDTH−1.
  - Goes to DONE when the synced `env_lo` is 0.
- DONE:
  - Writes `q_measured`, pulses `ready` and clears `timeout`.
  - Returns to SETTLE with `i_drive` unchanged, so the next measurement repeats at the same current.
- Timeout:
  - A timeout counter runs from entry to WAIT_HI.
  - If it reaches MAX_CYCLES before DONE, the block sets `q_measured=2^BUS_WIDTH−1`, `timeout=1` and pulses `ready`, then goes to SETTLE.
- `i_ref` change:
  - Compared each cycle against `i_drive` in every non-IDLE state.
  - On a mismatch the block aborts the current measurement: no `ready`, `excite` drops next cycle, `i_drive<=i_ref`, and the state goes to SETTLE.
  - This also applies in DONE: the result is not published and the block restarts.
- `enable` falling:
  - Any state → IDLE next cycle.
  - `excite=0`; `q_measured`, `timeout` and `i_drive` are held.
- Simultaneous events:
  - An `i_ref` change and a timeout in the same cycle: the change wins (no `ready`).
  - `enable=0` beats all other events.

## Timing
- Reset values (`rst_n=0` sampled at a `clk` edge): state IDLE, `i_drive=0`, `excite=0`, `q_measured=0`, `ready=0`, `timeout=0`, `busy=0`, all counters 0, all synchroniser FFs 0.
- Reset takes effect mid-measurement on the next edge; no `ready` is issued.
- `excite` rises 1+SETTLE_CYCLES cycles after the IDLE→SETTLE edge and stays high exactly EXCITE_CYCLES cycles.
- Input-to-state latency: 2 cycles for `env_*`, 3 cycles for `osc_in` edges.
- `ready` is high for exactly one cycle. The earliest next `ready` is SETTLE_CYCLES+EXCITE_CYCLES+3 cycles later.
- All outputs are registered.

## Configuration
- `Q_METER_AVG_EN`:
  - Defined: DONE accumulates 4 consecutive counts in a BUS_WIDTH+2 accumulator. `ready` pulses only after the 4th count, with `q_measured=sum>>2` (truncating).
  - A timeout inside the sequence publishes the saturated value immediately and clears the accumulator.
  - An `i_ref` change, `enable` low or reset clears the accumulator.
  - Undefined: every measurement publishes directly as described in Operation.

## Test plan
- Reset and start: hold `rst_n=0` 3 cycles, then release with `enable=1`, `i_ref=300` → all outputs 0 after reset; `i_drive=300` one cycle after release; `excite` high for 32 cycles starting 65 cycles after the IDLE→SETTLE edge.
- Nominal measurement: after `excite` falls, drop `env_hi`, then apply 50 `osc_in` rising edges (period 8 cycles), then drop `env_lo` → one `ready` pulse with `q_measured=50`, `timeout=0`.
- Saturation: apply 1100 edges with BUS_WIDTH=10 → `q_measured=1023`, `timeout=0`.
- Timeout: keep `env_hi=1` forever with MAX_CYCLES=1000 → `ready` pulses 1000 cycles after WAIT_HI entry, with `q_measured=1023` and `timeout=1`.
- Abort: change `i_ref` 300→301 in the middle of COUNT → no `ready`; `excite` restarts after SETTLE; the next result reflects only post-change edges.
- Averaging (`Q_METER_AVG_EN`): counts 40, 41, 42, 44 → a single `ready` with `q_measured=41`; `enable` low after the 2nd count, then high → the next `ready` averages 4 fresh counts.

Source files
------------

// File: rtl/q_meter.sv
// q_meter: ring-down Q measurement front end (periods counted between envelope thresholds).
// Define Q_METER_AVG_EN to publish the truncated mean of 4 consecutive counts.
module q_meter #(
  parameter int BUS_WIDTH     = 10,
  parameter int SETTLE_CYCLES = 64,
  parameter int EXCITE_CYCLES = 32,
  parameter int MAX_CYCLES    = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [BUS_WIDTH-1:0] i_ref,
  input  logic                 osc_in,
  input  logic                 env_hi,
  input  logic                 env_lo,
  output logic [BUS_WIDTH-1:0] i_drive,
  output logic                 excite,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 ready,
  output logic                 timeout,
  output logic                 busy
);
  localparam int W  = BUS_WIDTH;
  localparam int PW = $clog2((SETTLE_CYCLES > EXCITE_CYCLES ? SETTLE_CYCLES : EXCITE_CYCLES) + 1);
  localparam int TW = $clog2(MAX_CYCLES + 1);
  localparam logic [W-1:0] SAT = '1;
`ifdef Q_METER_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, SETTLE, EXCITE, WAIT_HI, COUNT, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [W-1:0] per_q, per_d, drive_q, drive_d, qm_q, qm_d;
  logic [TW-1:0] to_q, to_d;
  logic [W+1:0] acc_q, acc_d, sum;
  logic [1:0] n_q, n_d, hi_q, lo_q;
  logic [2:0] osc_q;
  logic exc_q, exc_d, rdy_q, rdy_d, tof_q, tof_d, busy_q, rise;
  assign rise = osc_q[1] & ~osc_q[2];
  assign sum = acc_q + {2'b00, per_q};
  always_comb begin
    state_d = state_q;
    ph_d = ph_q;
    per_d = per_q;
    to_d = to_q;
    drive_d = drive_q;
    qm_d = qm_q;
    rdy_d = 1'b0;
    tof_d = tof_q;
    acc_d = acc_q;
    n_d = n_q;
    exc_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      acc_d = '0;
      n_d = '0;
    end else if (state_q == IDLE || i_ref != drive_q) begin
      // start, or restart on a new bias current without publishing
      state_d = SETTLE;
      ph_d = '0;
      drive_d = i_ref;
      acc_d = '0;
      n_d = '0;
    end else begin
      exc_d = state_q == EXCITE;
      case (state_q)
        SETTLE: begin
          ph_d = ph_q + 1'b1;
          if (ph_q == PW'(SETTLE_CYCLES - 1)) begin
            state_d = EXCITE;
            ph_d = '0;
          end
        end
        EXCITE: begin
          ph_d = ph_q + 1'b1;
          if (ph_q == PW'(EXCITE_CYCLES - 1)) begin
            state_d = WAIT_HI;
            ph_d = '0;
            to_d = '0;
          end
        end
        WAIT_HI, COUNT: begin
          to_d = to_q + 1'b1;
          if (to_q == TW'(MAX_CYCLES - 1)) begin
            state_d = SETTLE;
            qm_d = SAT;
            tof_d = 1'b1;
            rdy_d = 1'b1;
            acc_d = '0;
            n_d = '0;
          end else if (state_q == WAIT_HI) begin
            if (!hi_q[1]) begin
              per_d = '0;
              state_d = COUNT;
            end
          end else begin
            per_d = (rise && per_q != SAT) ? per_q + 1'b1 : per_q;
            state_d = lo_q[1] ? COUNT : DONE;
          end
        end
        DONE: begin
          state_d = SETTLE;
          if (AVG && n_q != 2'd3) begin
            acc_d = sum;
            n_d = n_q + 1'b1;
          end else begin
            qm_d = AVG ? sum[W+1:2] : per_q;
            rdy_d = 1'b1;
            tof_d = 1'b0;
            acc_d = '0;
            n_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q <= '0;
      per_q <= '0;
      to_q <= '0;
      drive_q <= '0;
      qm_q <= '0;
      acc_q <= '0;
      n_q <= '0;
      exc_q <= 1'b0;
      rdy_q <= 1'b0;
      tof_q <= 1'b0;
      busy_q <= 1'b0;
      osc_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      per_q <= per_d;
      to_q <= to_d;
      drive_q <= drive_d;
      qm_q <= qm_d;
      acc_q <= acc_d;
      n_q <= n_d;
      exc_q <= exc_d;
      rdy_q <= rdy_d;
      tof_q <= tof_d;
      busy_q <= state_d != IDLE;
      osc_q <= {osc_q[1:0], osc_in};
      hi_q <= {hi_q[0], env_hi};
      lo_q <= {lo_q[0], env_lo};
    end
  end
  assign i_drive = drive_q;
  assign excite = exc_q;
  assign q_measured = qm_q;
  assign ready = rdy_q;
  assign timeout = tof_q;
  assign busy = busy_q;
endmodule
